exp1_sweep_capture: RTL and testbench

//  Sequential stimulus/capture stage wrapped around the 4-input combinational exp1 block.
//  - Drives exp1's H,O,N,R inputs through all 16 combinations, ordered {H,O,N,R} = 0..15 (H is the MSB).
//  - Samples exp1's S output once per vector and assembles a 16-bit truth table.
//  - Compares the table against an expected table and reports the result through a start/done handshake.

---
 rtl/exp1_sweep_capture.sv | 96 +++++++++
 tb/tb_exp1_sweep_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exp1_sweep_capture.sv
// Sweeps the 4-input exp1 block through all 16 {H,O,N,R} vectors, captures S per vector
// into a truth table and compares it against EXPECTED_TT behind a start/done handshake.
`timescale 1ns/1ps
module exp1_sweep_capture #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED_TT   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    output logic        H,
    output logic        O,
    output logic        N,
    output logic        R,
    input  logic        S,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones_count,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] SETTLE_RELOAD = SETTLE_CYCLES[7:0];

    state_t     state;
    logic [3:0] vec;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vec         <= '0;
            cnt         <= '0;
            {H, O, N, R} <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            ones_count  <= '0;
            pass        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    {H, O, N, R} <= '0;
                    if (start) begin
                        state       <= SETTLE;
                        vec         <= '0;
                        cnt         <= SETTLE_RELOAD;
                        busy        <= 1'b1;
                        truth_table <= '0;
                        ones_count  <= '0;
                        pass        <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (!hold) begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            truth_table[vec] <= S;
                            ones_count       <= ones_count + {4'd0, S};
                            if (vec == 4'd15) begin
                                // pass is decided on the same edge as the last sample, so
                                // the final S is folded in directly rather than read back.
                                state        <= DONE;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                                pass         <= ({S, truth_table[14:0]} == EXPECTED_TT);
                                {H, O, N, R} <= '0;
                            end else begin
                                vec          <= vec + 4'd1;
                                cnt          <= SETTLE_RELOAD;
                                {H, O, N, R} <= vec + 4'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    {H, O, N, R} <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp1_sweep_capture.sv
// Bench for exp1_sweep_capture: random exp1 truth tables and hold patterns against a
// work-counting reference model, on a SETTLE=2 and a SETTLE=0 instance.
`timescale 1ns/1ps
module tb_exp1_sweep_capture;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_a, hold_a, h_a, o_a, n_a, r_a, s_a, busy_a, done_a, pass_a;
    logic [15:0] tt_a, f_a;
    logic [4:0]  oc_a;
    logic start_b, hold_b, h_b, o_b, n_b, r_b, s_b, busy_b, done_b, pass_b;
    logic [15:0] tt_b, f_b;
    logic [4:0]  oc_b;

    // exp1 stand-in: S looks up the bench-chosen truth table at the driven vector
    assign s_a = f_a[{h_a, o_a, n_a, r_a}];
    assign s_b = f_b[{h_b, o_b, n_b, r_b}];

    exp1_sweep_capture #(.SETTLE_CYCLES(2), .EXPECTED_TT(16'hF000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hold(hold_a),
        .H(h_a), .O(o_a), .N(n_a), .R(r_a), .S(s_a),
        .busy(busy_a), .done(done_a), .truth_table(tt_a), .ones_count(oc_a), .pass(pass_a)
    );

    exp1_sweep_capture #(.SETTLE_CYCLES(0), .EXPECTED_TT(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hold(hold_b),
        .H(h_b), .O(o_b), .N(n_b), .R(r_b), .S(s_b),
        .busy(busy_b), .done(done_b), .truth_table(tt_b), .ones_count(oc_b), .pass(pass_b)
    );

    logic        sel;
    logic [3:0]  vec_o;
    logic        busy_o, done_o, pass_o;
    logic [15:0] tt_o;
    logic [4:0]  oc_o;
    assign vec_o  = sel ? {h_b, o_b, n_b, r_b} : {h_a, o_a, n_a, r_a};
    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;
    assign pass_o = sel ? pass_b : pass_a;
    assign tt_o   = sel ? tt_b : tt_a;
    assign oc_o   = sel ? oc_b : oc_a;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic do_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic drive_hold(input logic v);
        if (sel) hold_b = v; else hold_a = v;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_vec"}, vec_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_tt"}, tt_o, 0);
        check({tag, "_ones"}, oc_o, 0);
        check({tag, "_pass"}, pass_o, 0);
    endtask

    // Reference: the sweep is 16*(settle+1) units of work; every non-held edge does one unit,
    // the vector on the pins is work/(settle+1), and done follows the edge finishing the work.
    task automatic sweep(input logic which, input int unsigned settle, input logic [15:0] f,
                         input logic [15:0] exp_tt, input int hold_mode, input logic keep_start);
        int unsigned total, work, cycles, held;
        logic hd;
        sel = which;
        if (which) f_b = f; else f_a = f;
        drive_start(1'b1);
        do_edge();
        check("accept_busy", busy_o, 1);
        check("accept_vec", vec_o, 0);
        check("accept_tt", tt_o, 0);
        check("accept_ones", oc_o, 0);
        check("accept_pass", pass_o, 0);
        if (!keep_start) drive_start(1'b0);
        total = 16 * (settle + 1);
        work = 0;
        cycles = 0;
        held = 0;
        while (work < total && cycles < 4000) begin
            case (hold_mode)
                1:       hd = ($urandom_range(0, 3) == 0);
                2:       hd = (work == 7 * (settle + 1)) && (held < 5);
                default: hd = 1'b0;
            endcase
            if (hd) held++;
            drive_hold(hd);
            do_edge();
            cycles++;
            if (!hd) work++;
            if (work < total) begin
                check("sweep_vec", vec_o, work / (settle + 1));
                check("sweep_busy", busy_o, 1);
                check("sweep_done", done_o, 0);
            end
        end
        drive_hold(1'b0);
        check("sweep_bound", (cycles < 4000), 1);
        check("done_pulse", done_o, 1);
        check("done_tt", tt_o, f);
        check("done_ones", oc_o, $countones(f));
        check("done_pass", pass_o, (f == exp_tt));
        check("done_busy", busy_o, 0);
        check("done_vec", vec_o, 0);
        do_edge();
        check("post_done", done_o, 0);
        check("post_busy", busy_o, 0);
        check("post_tt", tt_o, f);
        check("post_pass", pass_o, (f == exp_tt));
        if (keep_start) begin
            do_edge();
            check("restart_busy", busy_o, 1);
            check("restart_tt", tt_o, 0);
            check("restart_ones", oc_o, 0);
            check("restart_pass", pass_o, 0);
            drive_start(1'b0);
            rst = 1'b1;
            do_edge();
            rst = 1'b0;
            check_idle_zero("restart_rst");
        end
    endtask

    initial begin
        logic [15:0] f;
        logic        which;

        rst = 1'b1;
        start_a = 1'b1; hold_a = 1'b0; f_a = 16'hFFFF;
        start_b = 1'b1; hold_b = 1'b0; f_b = 16'hFFFF;
        sel = 1'b0;
        repeat (3) do_edge();
        check_idle_zero("reset_a");
        sel = 1'b1;
        #1;
        check_idle_zero("reset_b");
        start_a = 1'b0;
        start_b = 1'b0;
        rst = 1'b0;
        do_edge();

        // S = H & O on the SETTLE=2 instance, expected table matches
        sweep(1'b0, 2, 16'hF000, 16'hF000, 0, 1'b0);
        // S tied high, one vector per cycle
        sweep(1'b1, 0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        // S = R ^ N against a non-matching expected table
        sweep(1'b0, 2, 16'h6666, 16'hF000, 0, 1'b0);
        sweep(1'b1, 0, 16'h6666, 16'hFFFF, 0, 1'b0);
        // five-cycle hold parked on vector 7
        f = 16'($urandom);
        sweep(1'b0, 2, f, 16'hF000, 2, 1'b0);
        sweep(1'b1, 0, 16'hFFFF, 16'hFFFF, 2, 1'b0);
        // start held through the sweep and the done cycle
        f = 16'($urandom);
        sweep(1'b0, 2, f, 16'hF000, 0, 1'b1);

        // reset while vector 9 is on the pins, with start also high
        sel = 1'b0;
        f_a = 16'($urandom) | 16'h01FF;
        start_a = 1'b1;
        do_edge();
        start_a = 1'b0;
        repeat (27) do_edge();
        check("pre_rst_vec", vec_o, 9);
        rst = 1'b1;
        start_a = 1'b1;
        do_edge();
        rst = 1'b0;
        start_a = 1'b0;
        check_idle_zero("mid_rst");
        for (int i = 0; i < 60; i++) begin
            do_edge();
            check("mid_rst_no_done", done_o, 0);
            check("mid_rst_busy", busy_o, 0);
        end

        for (int k = 0; k < 8; k++) begin
            which = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f = which ? 16'hFFFF : 16'hF000;
            else f = 16'($urandom);
            sweep(which, which ? 0 : 2, f, which ? 16'hFFFF : 16'hF000, 1, 1'b0);
            repeat ($urandom_range(0, 3)) do_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
